// File: rtl/and_chain_pipe.sv
// rtl/and_chain_pipe.sv - pipelined AND chain, one register stage per AND term, valid/ready on both ends
// Optional registered parity output out_par when AND_CHAIN_PIPE_PARITY_EN is defined.
module and_chain_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [DEPTH*WIDTH-1:0] in_mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
`ifdef AND_CHAIN_PIPE_PARITY_EN
    output logic                   out_par,
`endif
    output logic [CNT_W-1:0]       out_count
);

    // Stage k keeps only masks k+1..DEPTH, packed back to back: a triangular store.
    function automatic int moff(input int k);
        return WIDTH * (k * DEPTH - (k * (k - 1)) / 2);
    endfunction

    localparam int MT = WIDTH * DEPTH * (DEPTH + 1) / 2;

    logic [DEPTH:0]            r_valid;
    logic [DEPTH:0][WIDTH-1:0] r_data;
    logic [MT-1:0]             r_msk;
    logic [CNT_W-1:0]          r_count;

    logic [DEPTH:0]            w_adv;
    logic [DEPTH:0]            w_vin;
    logic [DEPTH:0]            w_load;
    logic [DEPTH:0]            w_valid_nxt;
    logic [DEPTH:0][WIDTH-1:0] w_data_nxt;
    logic [MT-1:0]             w_msk_nxt;

    genvar k;
    generate
        for (k = 0; k <= DEPTH; k++) begin : g_stage
            // A stage moves when it is empty or every stage after it is able to move.
            assign w_adv[k]       = ~(&r_valid[DEPTH:k]) | out_ready;
            assign w_load[k]      = w_adv[k] & w_vin[k];
            assign w_valid_nxt[k] = w_adv[k] ? w_vin[k] : r_valid[k];

            if (k == 0) begin : g_head
                assign w_vin[k]      = in_valid;
                assign w_data_nxt[k] = w_load[k] ? in_data : r_data[k];
                assign w_msk_nxt[0 +: DEPTH*WIDTH] =
                    w_load[k] ? in_mask : r_msk[0 +: DEPTH*WIDTH];
            end else begin : g_term
                localparam int PO = moff(k - 1);
                assign w_vin[k]      = r_valid[k-1];
                assign w_data_nxt[k] =
                    w_load[k] ? (r_data[k-1] & r_msk[PO +: WIDTH]) : r_data[k];
                if (k < DEPTH) begin : g_fwd
                    localparam int MO = moff(k);
                    localparam int MW = (DEPTH - k) * WIDTH;
                    assign w_msk_nxt[MO +: MW] =
                        w_load[k] ? r_msk[PO + WIDTH +: MW] : r_msk[MO +: MW];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_data  <= '0;
            r_msk   <= '0;
            r_count <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
            r_msk   <= w_msk_nxt;
            if (r_valid[DEPTH] && out_ready) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

`ifdef AND_CHAIN_PIPE_PARITY_EN
    logic             r_par;
    logic [WIDTH-1:0] w_last;

    assign w_last = r_data[DEPTH-1] & r_msk[moff(DEPTH - 1) +: WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par <= 1'b0;
        end else if (w_load[DEPTH]) begin
            r_par <= ^w_last;
        end
    end

    assign out_par = r_par;
`endif

    assign in_ready  = w_adv[0];
    assign out_valid = r_valid[DEPTH];
    assign out_data  = r_data[DEPTH];
    assign out_count = r_count;

endmodule
